// File: rtl/fpm_exc_pipe.sv
// fpm_exc_pipe: pipelined special-case classifier for the FP multiplier.
// Classifies both operands in stage 0, delays the result through LAT stages
// under a simple valid/ready stall, and keeps sticky {invalid, overflow,
// underflow} flags that update on output handshake.
// Optional build macro FPM_EXC_SNAN_EN: a signalling NaN input (fraction MSB
// clear) also raises the invalid flag.

module fpm_exc_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned FRC_W = 23,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DAZ   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+FRC_W:0]     op_x,
    input  logic [EXP_W+FRC_W:0]     op_y,
    input  logic                     udrf,
    input  logic                     ovrf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     nan,
    output logic                     inf,
    output logic                     zer,
    output logic                     den,
    output logic                     spec,
    output logic [EXP_W+FRC_W:0]     spec_res,
    output logic [2:0]               flags,
    input  logic                     flag_clr
);

    localparam int unsigned W      = 1 + EXP_W + FRC_W;
    localparam int unsigned PW     = W + 8;
    localparam int unsigned B_UDF  = W;
    localparam int unsigned B_OVF  = W + 1;
    localparam int unsigned B_INV  = W + 2;
    localparam int unsigned B_DEN  = W + 3;
    localparam int unsigned B_ZER  = W + 4;
    localparam int unsigned B_INF  = W + 5;
    localparam int unsigned B_NAN  = W + 6;
    localparam int unsigned B_SPEC = W + 7;

    // Reject unsupported pipeline depths at elaboration.
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("fpm_exc_pipe: LAT must be in 1..4");
    end

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;
    logic [PW-1:0]  pay_q [LAT];
    logic [PW-1:0]  pay_d [LAT];
    logic [2:0]     flags_q;
    logic [2:0]     flags_d;
    logic [PW-1:0]  cls_c;
    logic           advance_c;
    logic           hs_c;

    assign advance_c = out_ready | ~vld_q[LAT-1];
    assign hs_c      = vld_q[LAT-1] & out_ready;

    // Stage-0 classification of the incoming beat; bubbles carry zeros.
    always_comb begin
        logic             e_x, z_x, f_x, e_y, z_y, f_y;
        logic             nan_x, inf_x, zer_x, den_x;
        logic             nan_y, inf_y, zer_y, den_y;
        logic             inv_ev, c_nan, c_inf, c_zer, s;
        logic [W-1:0]     res;
        cls_c = '0;
        res   = '0;
        e_x   = &op_x[W-2 -: EXP_W];
        z_x   = ~|op_x[W-2 -: EXP_W];
        f_x   = |op_x[FRC_W-1:0];
        e_y   = &op_y[W-2 -: EXP_W];
        z_y   = ~|op_y[W-2 -: EXP_W];
        f_y   = |op_y[FRC_W-1:0];
        nan_x = e_x & f_x;
        inf_x = e_x & ~f_x;
        nan_y = e_y & f_y;
        inf_y = e_y & ~f_y;
        if (DAZ != 0) begin
            zer_x = z_x;
            zer_y = z_y;
            den_x = 1'b0;
            den_y = 1'b0;
        end else begin
            zer_x = z_x & ~f_x;
            zer_y = z_y & ~f_y;
            den_x = z_x & f_x;
            den_y = z_y & f_y;
        end
        inv_ev = (inf_x & zer_y) | (zer_x & inf_y);
        c_nan  = nan_x | nan_y | inv_ev;
        c_inf  = ~c_nan & (inf_x | inf_y | ovrf);
        c_zer  = ~c_nan & ~c_inf & (zer_x | zer_y | udrf);
        s      = op_x[W-1] ^ op_y[W-1];
`ifdef FPM_EXC_SNAN_EN
        // Signalling NaN inputs are invalid operations as well.
        inv_ev = inv_ev | (nan_x & ~op_x[FRC_W-1]) | (nan_y & ~op_y[FRC_W-1]);
`endif
        if (c_nan) begin
            res[W-2 -: EXP_W] = '1;
            res[FRC_W-1]      = 1'b1;
        end else if (c_inf) begin
            res[W-1]          = s;
            res[W-2 -: EXP_W] = '1;
        end else if (c_zer) begin
            res[W-1]          = s;
        end
        if (in_valid) begin
            cls_c[W-1:0]  = res;
            cls_c[B_UDF]  = udrf;
            cls_c[B_OVF]  = ovrf;
            cls_c[B_INV]  = inv_ev;
            cls_c[B_DEN]  = den_x | den_y;
            cls_c[B_ZER]  = c_zer;
            cls_c[B_INF]  = c_inf;
            cls_c[B_NAN]  = c_nan;
            cls_c[B_SPEC] = c_nan | c_inf | c_zer;
        end
    end

    // Shift the whole pipe on advance, otherwise hold every stage.
    always_comb begin
        vld_d = vld_q;
        for (int unsigned i = 0; i < LAT; i++) begin
            pay_d[i] = pay_q[i];
        end
        if (advance_c) begin
            vld_d[0] = in_valid;
            pay_d[0] = cls_c;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                pay_d[i] = pay_q[i-1];
            end
        end
    end

    // Sticky flags: clear first, then OR in events from an output handshake.
    always_comb begin
        flags_d = flag_clr ? 3'b000 : flags_q;
        if (hs_c) begin
            flags_d = flags_d | {pay_q[LAT-1][B_INV], pay_q[LAT-1][B_OVF],
                                 pay_q[LAT-1][B_UDF]};
        end
    end

    // Pipeline and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            flags_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            flags_q <= flags_d;
            for (int unsigned i = 0; i < LAT; i++) begin
                pay_q[i] <= pay_d[i];
            end
        end
    end

    assign in_ready  = advance_c;
    assign out_valid = vld_q[LAT-1];
    assign nan       = pay_q[LAT-1][B_NAN];
    assign inf       = pay_q[LAT-1][B_INF];
    assign zer       = pay_q[LAT-1][B_ZER];
    assign den       = pay_q[LAT-1][B_DEN];
    assign spec      = pay_q[LAT-1][B_SPEC];
    assign spec_res  = pay_q[LAT-1][W-1:0];
    assign flags     = flags_q;

endmodule

// File: tb/tb_fpm_exc_pipe.sv
// Bench for fpm_exc_pipe: directed cases plus randomized traffic, checked
// against a class-level reference model and an in-order scoreboard.
// A DAZ=1 and a DAZ=0 instance see the same stimulus.

module tb_fpm_exc_pipe;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned FRC_W = 23;
    localparam int unsigned LAT   = 2;
`ifdef FPM_EXC_SNAN_EN
    localparam bit SNAN_EN = 1'b1;
`else
    localparam bit SNAN_EN = 1'b0;
`endif

    localparam int K_NORM = 0;
    localparam int K_ZERO = 1;
    localparam int K_INF  = 2;
    localparam int K_NAN  = 3;
    localparam int K_DEN  = 4;

    typedef struct packed {
        logic        nan;
        logic        inf;
        logic        zer;
        logic        den;
        logic        spec;
        logic [31:0] res;
        logic        inv;
        logic        ovf;
        logic        udf;
    } cls_t;

    typedef struct {
        cls_t a;
        cls_t b;
        int   acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, udrf, ovrf, out_ready, flag_clr;
    logic [31:0] op_x, op_y;
    logic        in_ready, out_valid, nan, inf, zer, den, spec;
    logic [31:0] spec_res;
    logic [2:0]  flags;
    logic        in_ready0, out_valid0, nan0, inf0, zer0, den0, spec0;
    logic [31:0] spec_res0;
    logic [2:0]  flags0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          npop = 0;
    int          last_lat = 0;
    bit          last_acc;
    logic [2:0]  mdl_flags = 3'b000;
    exp_t        sb[$];
    logic        l_nan, l_inf, l_zer;
    logic [31:0] l_res;
    logic        l0_zer, l0_den, l0_spec;

    always #5 clk = ~clk;

    fpm_exc_pipe #(.EXP_W(EXP_W), .FRC_W(FRC_W), .LAT(LAT), .DAZ(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_x(op_x), .op_y(op_y), .udrf(udrf), .ovrf(ovrf),
        .out_valid(out_valid), .out_ready(out_ready), .nan(nan), .inf(inf),
        .zer(zer), .den(den), .spec(spec), .spec_res(spec_res),
        .flags(flags), .flag_clr(flag_clr)
    );

    fpm_exc_pipe #(.EXP_W(EXP_W), .FRC_W(FRC_W), .LAT(LAT), .DAZ(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .op_x(op_x), .op_y(op_y), .udrf(udrf), .ovrf(ovrf),
        .out_valid(out_valid0), .out_ready(out_ready), .nan(nan0), .inf(inf0),
        .zer(zer0), .den(den0), .spec(spec0), .spec_res(spec_res0),
        .flags(flags0), .flag_clr(flag_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int kind(input logic [31:0] v, input bit daz);
        if (v[30:23] == 8'hFF) return (v[22:0] != 0) ? K_NAN : K_INF;
        if (v[30:23] == 8'h00) begin
            if (v[22:0] == 0 || daz) return K_ZERO;
            return K_DEN;
        end
        return K_NORM;
    endfunction

    // Reference model: operand kinds -> result class, special word and events.
    function automatic cls_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic u, input logic o, input bit daz);
        cls_t c;
        int   kx, ky;
        bit   izero, s;
        c     = '0;
        kx    = kind(x, daz);
        ky    = kind(y, daz);
        s     = x[31] ^ y[31];
        izero = (kx == K_INF && ky == K_ZERO) || (kx == K_ZERO && ky == K_INF);
        if (kx == K_NAN || ky == K_NAN || izero) begin
            c.nan = 1'b1;
            c.res = 32'h7FC0_0000;
        end else if (kx == K_INF || ky == K_INF || o) begin
            c.inf = 1'b1;
            c.res = {s, 8'hFF, 23'h0};
        end else if (kx == K_ZERO || ky == K_ZERO || u) begin
            c.zer = 1'b1;
            c.res = {s, 31'h0};
        end
        c.spec = c.nan | c.inf | c.zer;
        c.den  = (kx == K_DEN) || (ky == K_DEN);
        c.inv  = izero;
        if (SNAN_EN && ((kx == K_NAN && !x[22]) || (ky == K_NAN && !y[22]))) c.inv = 1'b1;
        c.ovf  = o;
        c.udf  = u;
        return c;
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        s = 1'($urandom);
        case ($urandom % 6)
            0:       return {s, 31'h0};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            3:       return {s, 8'hFF, 1'b0, 22'($urandom) | 22'h1};
            4:       return {s, 8'h00, 23'($urandom) | 23'h1};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic beat(input logic [31:0] x, input logic [31:0] y,
                        input logic u, input logic o);
        in_valid = 1'b1;
        op_x     = x;
        op_y     = y;
        udrf     = u;
        ovrf     = o;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op_x     = '0;
        op_y     = '0;
        udrf     = 1'b0;
        ovrf     = 1'b0;
    endtask

    // One clock: check outputs against the scoreboard, update the models.
    task automatic tick();
        bit         hs;
        logic [2:0] ev;
        exp_t       e;
        #1;
        chk("flags", 64'(flags), 64'(mdl_flags));
        chk("valid_daz0", 64'(out_valid0), 64'(out_valid));
        hs       = out_valid && out_ready;
        last_acc = in_valid && in_ready;
        ev       = 3'b000;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb[0];
                chk("nan",      64'(nan),       64'(e.a.nan));
                chk("inf",      64'(inf),       64'(e.a.inf));
                chk("zer",      64'(zer),       64'(e.a.zer));
                chk("den",      64'(den),       64'(e.a.den));
                chk("spec",     64'(spec),      64'(e.a.spec));
                chk("res",      64'(spec_res),  64'(e.a.res));
                chk("nan_d0",   64'(nan0),      64'(e.b.nan));
                chk("inf_d0",   64'(inf0),      64'(e.b.inf));
                chk("zer_d0",   64'(zer0),      64'(e.b.zer));
                chk("den_d0",   64'(den0),      64'(e.b.den));
                chk("spec_d0",  64'(spec0),     64'(e.b.spec));
                chk("res_d0",   64'(spec_res0), 64'(e.b.res));
                if (hs) begin
                    ev       = {e.a.inv, e.a.ovf, e.a.udf};
                    last_lat = cyc - e.acc;
                    l_nan = nan; l_inf = inf; l_zer = zer; l_res = spec_res;
                    l0_zer = zer0; l0_den = den0; l0_spec = spec0;
                    void'(sb.pop_front());
                    npop++;
                end
            end
        end
        mdl_flags = (flag_clr ? 3'b000 : mdl_flags) | ev;
        if (last_acc) begin
            e.a   = model(op_x, op_y, udrf, ovrf, 1'b1);
            e.b   = model(op_x, op_y, udrf, ovrf, 1'b0);
            e.acc = cyc;
            sb.push_back(e);
        end
        if (rst) begin
            sb.delete();
            mdl_flags = 3'b000;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] bx[4];
        logic [31:0] by[4];
        logic [31:0] snap_res;
        logic [3:0]  snap_cls;
        int          k, n, p0;

        rst = 1'b1; flag_clr = 1'b0; out_ready = 1'b1;
        idle();
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_spec",      64'(spec),      64'd0);
        chk("rst_res",       64'(spec_res),  64'd0);
        chk("rst_flags",     64'(flags),     64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Inf x Zero: invalid, canonical quiet NaN, latency LAT.
        beat(32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        drain();
        chk("t1_lat",   64'(last_lat), 64'(LAT));
        chk("t1_nan",   64'(l_nan),    64'd1);
        chk("t1_res",   64'(l_res),    64'h7FC0_0000);
        chk("t1_flags", 64'(flags),    64'b100);

        // Signed infinity, then multiplier overflow.
        beat(32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b0);
        tick();
        drain();
        chk("t2_inf",   64'(l_inf),  64'd1);
        chk("t2_res",   64'(l_res),  64'hFF80_0000);
        chk("t2_flags", 64'(flags),  64'b100);
        beat(32'h7F00_0000, 32'h7F00_0000, 1'b0, 1'b1);
        tick();
        drain();
        chk("t2_ovf_inf",   64'(l_inf), 64'd1);
        chk("t2_ovf_flags", 64'(flags), 64'b110);

        // Denormal operand: zero under DAZ=1, denormal under DAZ=0.
        beat(32'h0000_0001, 32'h4000_0000, 1'b0, 1'b0);
        tick();
        drain();
        chk("t3_zer",     64'(l_zer),   64'd1);
        chk("t3_res",     64'(l_res),   64'd0);
        chk("t3_d0_zer",  64'(l0_zer),  64'd0);
        chk("t3_d0_den",  64'(l0_den),  64'd1);
        chk("t3_d0_spec", 64'(l0_spec), 64'd0);

        // Stall: four beats in, output held for three cycles.
        bx = '{32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h3F80_0000};
        by = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h7FC0_0001};
        p0 = npop;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 2; c++) begin
            beat(bx[k], by[k], 1'b0, 1'b0);
            tick();
            if (last_acc) k++;
        end
        snap_res = spec_res;
        snap_cls = {nan, inf, zer, spec};
        for (int c = 0; c < 3; c++) begin
            beat(bx[k], by[k], 1'b0, 1'b0);
            chk("stall_in_ready",  64'(in_ready),               64'd0);
            chk("stall_out_valid", 64'(out_valid),              64'd1);
            chk("stall_res",       64'(spec_res),               64'(snap_res));
            chk("stall_cls",       64'({nan, inf, zer, spec}),  64'(snap_cls));
            tick();
            if (last_acc) k++;
        end
        out_ready = 1'b1;
        n = 0;
        while (k < 4 && n < 20) begin
            beat(bx[k], by[k], 1'b0, 1'b0);
            tick();
            if (last_acc) k++;
            n++;
        end
        drain();
        chk("stall_count", 64'(npop - p0), 64'd4);

        // Flag clear racing a handshake that carries underflow.
        beat(32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0);
        tick();
        drain();
        chk("t5_flags_all", 64'(flags), 64'b111);
        beat(32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0);
        tick();
        idle();
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("t5_clr_vs_udf", 64'(flags), 64'b001);

        // Reset with two beats in flight.
        beat(32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        beat(32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0);
        tick();
        idle();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_flags",     64'(flags),     64'd0);
        for (int c = 0; c < 4; c++) tick();

        // Signalling NaN operand.
        beat(32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b0);
        tick();
        drain();
        chk("t7_nan",     64'(l_nan),    64'd1);
        chk("t7_res",     64'(l_res),    64'h7FC0_0000);
        chk("t7_invalid", 64'(flags[2]), 64'(SNAN_EN));

        // Randomized traffic with random back-pressure and flag clears.
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom % 8);
            beat(rand_op(), rand_op(), r == 0 || r == 2, r == 1 || r == 2);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            flag_clr  = ($urandom % 16) == 0;
            tick();
        end
        flag_clr = 1'b0;
        drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
